// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, sequencer state encoding and opcode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seq_state_t;

    function automatic logic isShift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU-side and response signals of the ALU sequencer; slave is the sequencer view.
interface alu_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               cmdValid;
    logic               cmdReady;
    logic [WIDTH-1:0]   cmdOperandA;
    logic [WIDTH-1:0]   cmdOperandB;
    logic [3:0]         cmdAluOp;
    logic [SHAMT_W-1:0] cmdShamt;

    logic [WIDTH-1:0]   aluOperandA;
    logic [WIDTH-1:0]   aluOperandB;
    logic [3:0]         aluOp;
    logic [WIDTH-1:0]   aluResult;
    logic               aluZero;
    logic               aluCarry;

    logic               rspValid;
    logic               rspReady;
    logic [WIDTH-1:0]   rspResult;
    logic               rspZero;
    logic               rspCarry;

    modport slave (
        input  cmdValid, cmdOperandA, cmdOperandB, cmdAluOp, cmdShamt,
        output cmdReady,
        output aluOperandA, aluOperandB, aluOp,
        input  aluResult, aluZero, aluCarry,
        output rspValid, rspResult, rspZero, rspCarry,
        input  rspReady
    );

    modport master (
        output cmdValid, cmdOperandA, cmdOperandB, cmdAluOp, cmdShamt,
        input  cmdReady,
        input  aluOperandA, aluOperandB, aluOp,
        output aluResult, aluZero, aluCarry,
        input  rspValid, rspResult, rspZero, rspCarry,
        output rspReady
    );
endinterface

// File: rtl/alu_sequencer.sv
// Feeds one command at a time to a sibling ALU, expanding N-bit shifts into N single-bit steps.
// Latency: 2 cycles (non-shift), 1+N (shift by N), 1 (shift by 0); rsp held until rspReady, no cmd overlap.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rstN,
    alu_sequencer_if.slave  bus
);

    seq_state_t         state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [3:0]         op_q;
    logic [SHAMT_W-1:0] count_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               cmd_rdy_q;
    logic               rsp_vld_q;

    assign bus.aluOperandA = opa_q;
    assign bus.aluOperandB = opb_q;
    assign bus.aluOp       = op_q;
    assign bus.cmdReady    = cmd_rdy_q;
    assign bus.rspValid    = rsp_vld_q;
    assign bus.rspResult   = result_q;
    assign bus.rspZero     = zero_q;
    assign bus.rspCarry    = carry_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            count_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            cmd_rdy_q <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmdValid && cmd_rdy_q) begin
                        cmd_rdy_q <= 1'b0;
                        // Zero-length shift bypasses the ALU; its inputs stay untouched.
                        if (isShift(bus.cmdAluOp) && (bus.cmdShamt == '0)) begin
                            result_q  <= bus.cmdOperandA;
                            zero_q    <= (bus.cmdOperandA == '0);
                            carry_q   <= 1'b0;
                            rsp_vld_q <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            opa_q   <= bus.cmdOperandA;
                            opb_q   <= bus.cmdOperandB;
                            op_q    <= bus.cmdAluOp;
                            count_q <= isShift(bus.cmdAluOp) ? bus.cmdShamt : SHAMT_W'(1);
                            state_q <= EXEC;
                        end
                    end else begin
                        cmd_rdy_q <= 1'b1;
                    end
                end
                EXEC: begin
                    // Result feeds back as operand A so each step shifts the previous one.
                    result_q <= bus.aluResult;
                    zero_q   <= bus.aluZero;
                    carry_q  <= bus.aluCarry;
                    opa_q    <= bus.aluResult;
                    count_q  <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        rsp_vld_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rspReady) begin
                        rsp_vld_q <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural single-step ALU beside it; table, directed and random checks.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        int          hold;
        logic [31:0] er;
        logic        ez;
        logic        ec;
        int          lat;
    } vec_t;

    logic clk;
    logic rstN;
    int   n_vec;
    int   n_err;
    vec_t vecs[15];

    alu_sequencer_if #(.WIDTH(W), .SHAMT_W(5)) bus();

    alu_sequencer #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ALU step, as the sibling ALU would compute it.
    always_comb begin
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        s = '0;
        r = '0;
        c = 1'b0;
        case (bus.aluOp)
            OP_ADD: begin s = {1'b0, bus.aluOperandA} + {1'b0, bus.aluOperandB}; r = s[31:0]; c = s[32]; end
            OP_SUB: begin r = bus.aluOperandA - bus.aluOperandB; c = (bus.aluOperandA < bus.aluOperandB); end
            OP_AND: r = bus.aluOperandA & bus.aluOperandB;
            OP_OR:  r = bus.aluOperandA | bus.aluOperandB;
            OP_XOR: r = bus.aluOperandA ^ bus.aluOperandB;
            OP_NOT: r = ~bus.aluOperandA;
            OP_SHL: begin r = {bus.aluOperandA[30:0], 1'b0}; c = bus.aluOperandA[31]; end
            OP_SHR: r = {1'b0, bus.aluOperandA[31:1]};
            default: r = '0;
        endcase
        bus.aluResult = r;
        bus.aluZero   = (r == '0);
        bus.aluCarry  = c;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-command reference: multi-bit shifts computed in one go.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic z,
                         output logic c, output int lat);
        logic [32:0] s;
        c   = 1'b0;
        lat = 2;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin
                r   = a << sh;
                c   = (sh == 0) ? 1'b0 : a[32 - int'(sh)];
                lat = 1 + int'(sh);
            end
            OP_SHR: begin r = a >> sh; lat = 1 + int'(sh); end
            default: r = '0;
        endcase
        z = (r == 0);
    endtask

    task automatic rsp_ack();
        bus.rspReady = 1'b1;
        @(posedge clk);
        #1 bus.rspReady = 1'b0;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh);
        bus.cmdValid    = 1'b1;
        bus.cmdAluOp    = op;
        bus.cmdOperandA = a;
        bus.cmdOperandB = b;
        bus.cmdShamt    = sh;
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input int hold,
                             input logic [31:0] er, input logic ez, input logic ec, input int el);
        int g;
        int lat;
        g = 0;
        @(negedge clk);
        while (!bus.cmdReady && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " accept"}, 64'(bus.cmdReady), 64'd1);
        drive_cmd(op, a, b, sh);
        @(posedge clk);
        #1;
        bus.cmdValid    = 1'b0;
        bus.cmdOperandA = $urandom;
        bus.cmdAluOp    = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rspValid && lat < 64);
        chk({tag, " latency"}, 64'(lat), 64'(el));
        chk({tag, " result"}, 64'(bus.rspResult), 64'(er));
        chk({tag, " zero/carry"}, 64'({bus.rspZero, bus.rspCarry}), 64'({ez, ec}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold"}, 64'({bus.rspValid, bus.cmdReady, bus.rspResult}), 64'({1'b1, 1'b0, er}));
        end
        rsp_ack();
        @(negedge clk);
        chk({tag, " release"}, 64'({bus.rspValid, bus.cmdReady}), 64'b01);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb, rr;
        logic [4:0]  rsh;
        logic        rz, rc;
        int          rlat;

        n_vec = 0;
        n_err = 0;
        rstN  = 1'b1;
        bus.cmdValid = 1'b0; bus.cmdOperandA = '0; bus.cmdOperandB = '0;
        bus.cmdAluOp = '0;   bus.cmdShamt = '0;    bus.rspReady = 1'b0;

        vecs[0]  = '{OP_ADD, 32'd5, 32'd7, 5'd0, 0, 32'd12, 1'b0, 1'b0, 2};
        vecs[1]  = '{OP_SUB, 32'd9, 32'd9, 5'd3, 0, 32'd0, 1'b1, 1'b0, 2};
        vecs[2]  = '{OP_SHL, 32'hC000_0001, 32'd0, 5'd2, 0, 32'h4, 1'b0, 1'b1, 3};
        vecs[3]  = '{OP_SHR, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1'b1, 1'b0, 1};
        vecs[4]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'd0, 1'b1, 1'b1, 2};
        vecs[5]  = '{OP_SUB, 32'd3, 32'd5, 5'd0, 0, 32'hFFFF_FFFE, 1'b0, 1'b1, 2};
        vecs[6]  = '{OP_NOT, 32'd0, 32'd0, 5'd0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2};
        vecs[7]  = '{OP_XOR, 32'hA5A5, 32'hFFFF, 5'd0, 2, 32'h5A5A, 1'b0, 1'b0, 2};
        vecs[8]  = '{OP_SHR, 32'h8000_0000, 32'd0, 5'd31, 0, 32'd1, 1'b0, 1'b0, 32};
        vecs[9]  = '{OP_SHL, 32'd1, 32'd0, 5'd31, 0, 32'h8000_0000, 1'b0, 1'b0, 32};
        vecs[10] = '{4'b1010, 32'd123, 32'd45, 5'd0, 0, 32'd0, 1'b1, 1'b0, 2};
        vecs[11] = '{OP_SHL, 32'h1234_5678, 32'd0, 5'd0, 0, 32'h1234_5678, 1'b0, 1'b0, 1};
        vecs[12] = '{OP_AND, 32'hF0F0, 32'hFF00, 5'd0, 0, 32'hF000, 1'b0, 1'b0, 2};
        vecs[13] = '{OP_OR, 32'hF0, 32'h0F, 5'd0, 5, 32'hFF, 1'b0, 1'b0, 2};
        vecs[14] = '{OP_SHL, 32'h1234_5678, 32'd0, 5'd4, 0, 32'h2345_6780, 1'b0, 1'b1, 5};

        // Reset state
        #3 rstN = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ready/valid", 64'({bus.cmdReady, bus.rspValid}), 64'b00);
        chk("reset alu outputs", 64'({bus.aluOp, bus.aluOperandA}), 64'd0);
        chk("reset aluOperandB", 64'(bus.aluOperandB), 64'd0);
        chk("reset rsp data", 64'({bus.rspResult, bus.rspZero, bus.rspCarry}), 64'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready after reset", 64'(bus.cmdReady), 64'd1);

        // Shift by zero: answered next cycle, ALU inputs untouched
        drive_cmd(OP_SHR, 32'd0, 32'd0, 5'd0);
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        @(negedge clk);
        chk("shr0 valid@1", 64'(bus.rspValid), 64'd1);
        chk("shr0 rsp", 64'({bus.rspResult, bus.rspZero, bus.rspCarry}), 64'({32'd0, 1'b1, 1'b0}));
        chk("shr0 alu untouched", 64'({bus.aluOp, bus.aluOperandA}), 64'd0);
        rsp_ack();

        // SHL by 2: operand A walks through the intermediate value
        @(negedge clk);
        drive_cmd(OP_SHL, 32'hC000_0001, 32'h1111, 5'd2);
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        @(negedge clk);
        chk("shl2 step1 opA", 64'({bus.aluOp, bus.aluOperandA}), 64'({OP_SHL, 32'hC000_0001}));
        chk("shl2 no early valid", 64'(bus.rspValid), 64'd0);
        @(negedge clk);
        chk("shl2 step2 opA", 64'(bus.aluOperandA), 64'h8000_0002);
        chk("shl2 no early valid2", 64'(bus.rspValid), 64'd0);
        @(negedge clk);
        chk("shl2 valid@3", 64'(bus.rspValid), 64'd1);
        chk("shl2 rsp", 64'({bus.rspResult, bus.rspZero, bus.rspCarry}), 64'({32'h4, 1'b0, 1'b1}));
        rsp_ack();

        for (int i = 0; i < 15; i++)
            check_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                      vecs[i].hold, vecs[i].er, vecs[i].ez, vecs[i].ec, vecs[i].lat);

        // Backpressure with a second command held valid during RESP
        @(negedge clk);
        drive_cmd(OP_OR, 32'hF0, 32'h0F, 5'd0);
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp first rsp", 64'({bus.rspValid, bus.rspResult}), 64'({1'b1, 32'hFF}));
        drive_cmd(OP_ADD, 32'd3, 32'd4, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold", 64'({bus.rspValid, bus.cmdReady, bus.rspResult}), 64'({1'b1, 1'b0, 32'hFF}));
        end
        rsp_ack();
        @(negedge clk);
        chk("bp ready after ack", 64'({bus.cmdReady, bus.rspValid}), 64'b10);
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        @(negedge clk);
        chk("bp second accepted", 64'({bus.cmdReady, bus.aluOp, bus.aluOperandA}), 64'({1'b0, OP_ADD, 32'd3}));
        @(negedge clk);
        chk("bp second rsp", 64'({bus.rspValid, bus.rspResult}), 64'({1'b1, 32'd7}));
        rsp_ack();

        // Reset in the middle of a long shift
        @(negedge clk);
        drive_cmd(OP_SHR, 32'hFFFF_FFFF, 32'd0, 5'd31);
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        repeat (10) @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("abort alu outputs", 64'({bus.aluOp, bus.aluOperandA}), 64'd0);
        chk("abort opB", 64'(bus.aluOperandB), 64'd0);
        chk("abort rsp", 64'({bus.rspValid, bus.cmdReady, bus.rspResult, bus.rspZero, bus.rspCarry}), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("abort ready", 64'(bus.cmdReady), 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rspValid) chk("abort stale rsp", 64'(bus.rspValid), 64'd0);
        end
        chk("abort no rsp", 64'(bus.rspValid), 64'd0);
        check_cmd("abort next add", OP_ADD, 32'd1, 32'd1, 5'd0, 0, 32'd2, 1'b0, 1'b0, 2);

        // Random commands against the whole-command reference
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            rsh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rsh = 5'($urandom_range(0, 2));
            model(rop, ra, rb, rsh, rr, rz, rc, rlat);
            check_cmd($sformatf("rnd%0d op%0h", i, rop), rop, ra, rb, rsh,
                      $urandom_range(0, 2), rr, rz, rc, rlat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Upstream command stage for the ALU. It accepts one ALU command per valid/ready handshake and registers the operands. It drives the ALU's operand and opcode inputs and captures the result and flags. It turns multi-bit shifts into repeated single-bit ALU shifts, then returns the final result through a valid/ready response port. The ALU is instantiated beside it, with the sequencer's alu* outputs wired to the ALU inputs and the ALU outputs wired back.

Parameters:
WIDTH, 32, datapath width; must match the ALU's WIDTH.
SHAMT_W, 5, shift-count width; equals $clog2(WIDTH).

Ports:
clk  input  1  single clock, all state on rising edge
rstN  input  1  asynchronous, active-low reset
cmdValid  input  1  command valid
cmdReady  output  1  command accepted when cmdValid && cmdReady
cmdOperandA  input  WIDTH  operand A
cmdOperandB  input  WIDTH  operand B
cmdAluOp  input  4  ALU opcode
cmdShamt  input  SHAMT_W  shift count; used only for SHL/SHR, ignored otherwise
aluOperandA  output  WIDTH  to ALU operandA
aluOperandB  output  WIDTH  to ALU operandB
aluOp  output  4  to ALU opcode
aluResult  input  WIDTH  from ALU result
aluZero  input  1  from ALU zero flag
aluCarry  input  1  from ALU carry-out
rspValid  output  1  response valid
rspReady  input  1  response consumed when rspValid && rspReady
rspResult  output  WIDTH  final result
rspZero  output  1  final result == 0
rspCarry  output  1  carry-out of the last ALU step

Behaviour:
- Reset (rstN low, asynchronous, one clock, no synchronous reset):
  - State goes to IDLE.
  - opA/opB/op/count/result/zero/carry registers clear to 0.
  - rspValid=0; cmdReady=0 while rstN low.
  - alu* outputs = 0 (ADD of 0,0).
- Reset mid-operation aborts the command: no response is produced and no stale data appears after release.
- ALU outputs always come straight from the internal registers, never combinationally from cmd* inputs.
- FSM states IDLE, EXEC, RESP:
  - IDLE: cmdReady=1. On handshake, latch cmdOperandA/B, cmdAluOp, cmdShamt.
    - SHL/SHR with shamt==0: go to RESP with result=opA, zero=(opA==0), carry=0. ALU not used.
    - Any other command: go to EXEC with count=shamt (shifts) or 1 (non-shift).
  - EXEC: each cycle, capture aluResult, aluZero, aluCarry; opA <= aluResult; count--. When count==1, go to RESP.
  - RESP: rspValid=1; rspResult/rspZero/rspCarry held stable until rspReady. On handshake, go to IDLE. cmdReady=0 throughout.
- Latency from cmd handshake at cycle T to first rspValid:
  - non-shift: T+2
  - shift by N≥1: T+1+N
  - shift by 0: T+1
- No overlap: the next cmd can be accepted at the earliest one cycle after the rsp handshake.
- Opcodes 1000–1111 (invalid) run as a single step. They return whatever the ALU gives: 0, zero=1, carry=0.
- SHL carry = bit shifted out on the final step. SHR is logical (zero-fill), carry=0.
- Arithmetic wraps modulo 2^WIDTH; the sequencer adds no width extension.
- cmdValid while not IDLE is ignored and must be held by the source; AXI-style rules apply.
- rspValid must not depend combinationally on rspReady.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_XOR=0100, OP_NOT=0101, OP_SHL=0110, OP_SHR=0111.
  - Sequencer state enum {IDLE, EXEC, RESP}.
  - Helper function isShift(op).
- No sub-module: the FSM, counter and registers are one block. The ALU stays a sibling, wired at the parent and in the bench.

Test Plan:
1. ADD A=5, B=7, accepted cycle 0, rspReady=1 -> rspValid at cycle 2; result=12, zero=0, carry=0; cmdReady=1 at cycle 3.
2. SUB A=9, B=9 -> result=0x0, zero=1, carry=0.
3. SHL A=0xC000_0001, shamt=2 -> aluOperandA 0xC000_0001 then 0x8000_0002; rspValid at cycle 3; result=0x0000_0004, carry=1, zero=0.
4. SHR A=0x0, shamt=0 -> rspValid at cycle 1; result=0, zero=1, carry=0; aluOp never leaves reset value in between.
5. OR A=0xF0, B=0x0F with rspReady low for 5 cycles -> rspResult=0xFF stable, rspValid held, cmdReady=0. A second cmd held valid is accepted exactly one cycle after the rsp handshake.
6. SHR A=0xFFFF_FFFF, shamt=31, rstN pulsed low at the 10th EXEC cycle -> all outputs 0 immediately. After release: cmdReady=1, rspValid stays 0, and the next ADD 1+1 returns 2.
